// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC sequencer holding PC, IR and next-PC selection.
// Optional FETCH_INSTR_COUNT_EN adds a retired-instruction counter output (instrCount).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [31:0] pcOut,
    output logic        instrValid
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [31:0] instrCount
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_capture;
    logic              w_retire;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_pc_out;
    logic [XLEN-1:0]   r_ir;
    logic              r_req;
    logic              r_valid;
    logic [XLEN-1:0]   w_pc4;
    logic [XLEN-1:0]   w_br_off;
    logic [XLEN-1:0]   w_pc_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transition strobes; ack only matters in FETCH, stall only in EXEC
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (imemAck) begin
                    w_state_nxt = EXEC;
                    w_capture   = 1'b1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    w_state_nxt = FETCH;
                    w_retire    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next-PC selection from the instruction in IR; Jump outranks Branch
    always_comb begin
        w_pc4     = r_pc_out + XLEN'(4);
        w_br_off  = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
        w_pc_next = w_pc4;
        if (Jump) begin
            w_pc_next = {w_pc4[31:28], r_ir[25:0], 2'b00};
        end else if (Branch && Zero) begin
            w_pc_next = w_pc4 + w_br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_pc_out <= RESET_PC;
            r_ir     <= '0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_req   <= (w_state_nxt == FETCH);
            r_valid <= (w_state_nxt == EXEC);
            if (w_capture) begin
                r_ir     <= imemData;
                r_pc_out <= r_pc;
            end
            if (w_retire) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign imemReq    = r_req;
    assign imemAddr   = r_pc;
    assign instr      = r_ir;
    assign opCode     = r_ir[31:26];
    assign pcOut      = r_pc_out;
    assign instrValid = r_valid;

`ifdef FETCH_INSTR_COUNT_EN
    logic [XLEN-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + XLEN'(1);
        end
    end

    assign instrCount = r_count;
`endif

endmodule
